alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Programmable run controller for the 16-bit Hack-style ALU and its two 32-entry operand memories.
//  Holds a small op program: per entry, operand addresses, ALU control bits and an expected result.
//  On start: pulses initialise to preload the operand memories, then issues each op in order.
//  Captures result and flags for each op, checks the result against the expected value and reports a mismatch summary.
// PARAMETERS
//  PROG_DEPTH  16  program entries (power of 2); index width PW = log2(PROG_DEPTH)
//  DATA_W      16  ALU data width
//  ADDR_W      5   operand memory address width
// PORTS
//  clk            in   1       system clock, all state on posedge
//  rst            in   1       synchronous active-high reset
//  prog_we        in   1       program write strobe
//  prog_addr      in   PW      program entry index
//  prog_data      in   32      [31:16] expected, [15:11] addr_a, [10:6] addr_b, [5:0] {zx,nx,zy,ny,f,no}
//  start          in   1       run request (level sampled in IDLE)
//  op_count       in   PW+1    number of ops to run, entries 0..op_count-1
//  initialise     out  1       operand memory preload strobe
//  address_a      out  ADDR_W  operand A address
//  address_b      out  ADDR_W  operand B address
//  zx,nx,zy,ny,f,no out 1 each ALU control
//  alu_result     in   DATA_W  ALU output (combinational from the addresses and control bits)
//  alu_zr, alu_ng in   1       ALU flags
//  busy           out  1       high in all states except IDLE
//  done           out  1       single-cycle pulse at end of run
//  last_result    out  DATA_W  result captured from most recent op
//  last_zr,last_ng out 1       flags captured with last_result
//  err_count      out  PW+1    ops whose result != expected in current/last run
//  first_err_idx  out  PW+1    index of first mismatching op; all-ones = none
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state -> IDLE.
//   - All outputs 0, except first_err_idx = all-ones.
//   - Program memory contents are NOT cleared.
//   - Reset mid-run aborts immediately; no done pulse is produced.
//  Program write: in IDLE, prog_we=1 writes prog_data at prog_addr on posedge. Writes while busy are dropped.
//  FSM states: IDLE, INIT, FETCH, EXEC, CHECK, DONE.
//   IDLE: start=1 -> latch op_count, saturated to PROG_DEPTH; clear err_count, idx; first_err_idx=all-ones.
//     If latched count == 0 -> go to DONE; otherwise go to INIT.
//   INIT: initialise=1 for exactly this one cycle. Next state is FETCH.
//   FETCH: register program entry idx into the op register. Next state is EXEC.
//   EXEC: address_a, address_b and control bits are driven from the op register; alu_result settles.
//     At the posedge ending EXEC: capture last_result, last_zr and last_ng. Next state is CHECK.
//   CHECK: compare last_result with the expected value.
//     On mismatch: err_count++; if first_err_idx is all-ones, set it to idx.
//     Then idx++. If idx+1 == count go to DONE; otherwise go to FETCH.
//   DONE: done=1 for this cycle only. Next state is IDLE.
//  Outputs during run:
//   - address/control outputs hold the last issued op outside EXEC; they are 0 before the first op.
//   - initialise is high only in INIT.
//  Timing: start sampled at edge E0 -> INIT in cycle 1; 3 cycles per op; done high in cycle 3N+2 (N >= 1).
//   N == 0: done is high in cycle 1, with no INIT and no ALU activity.
//  start asserted while busy is ignored. start held high during DONE begins a new run from IDLE on the next cycle.
//  Results and error summary are held until the next accepted start or rst.
// TESTING
//  1. prog[0]={exp 3, a=1, b=2, ctrl 000010}, op_count=1, start
//     -> initialise pulse in cycle 1; done in cycle 5; last_result=3, zr=0, ng=0; err_count=0; first_err_idx=1F.
//  2. prog[0]={exp 0, a=12(-1), b=1, ctrl 000010}
//     -> last_result=0, last_zr=1, err_count=0.
//  3. 4 ops, entry 2 has a wrong expected value
//     -> done in cycle 14; err_count=1; first_err_idx=2; last_result = entry 3 result.
//  4. op_count=0, start
//     -> done in cycle 1; initialise never asserted; busy high for 1 cycle.
//  5. rst asserted during EXEC of op 1 of 3
//     -> next cycle IDLE, all outputs 0, first_err_idx=1F, no done; a rerun reuses the retained program.
//  6. start and prog_we pulsed while busy
//     -> no restart; program memory unchanged; run completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Run controller for a Hack-style ALU and its operand memories.
//             Preloads the operand memories, steps through a small op
//             program, captures each ALU result and tallies result mismatches.
//  Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    localparam int PW        = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [PW-1:0]     prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              start,
    input  logic [PW:0]       op_count,
    output logic              initialise,
    output logic [ADDR_W-1:0] address_a,
    output logic [ADDR_W-1:0] address_b,
    output logic              zx,
    output logic              nx,
    output logic              zy,
    output logic              ny,
    output logic              f,
    output logic              no,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] last_result,
    output logic              last_zr,
    output logic              last_ng,
    output logic [PW:0]       err_count,
    output logic [PW:0]       first_err_idx
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_INIT  = 3'd1;
    localparam logic [2:0] c_FETCH = 3'd2;
    localparam logic [2:0] c_EXEC  = 3'd3;
    localparam logic [2:0] c_CHECK = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    localparam logic [PW:0] c_DEPTH = (PW+1)'(PROG_DEPTH);
    localparam logic [PW:0] c_NONE  = '1;

    logic [2:0]        r_state;
    logic [PW:0]       r_count;
    logic [PW:0]       r_idx;
    logic [31:0]       r_op;
    logic [DATA_W-1:0] r_last_result;
    logic              r_last_zr;
    logic              r_last_ng;
    logic [PW:0]       r_err_count;
    logic [PW:0]       r_first_err_idx;
    logic [31:0]       r_prog [PROG_DEPTH];

    logic [PW:0]       w_sat_count;
    logic [PW:0]       w_idx_next;
    logic              w_mismatch;

    assign w_sat_count = (op_count > c_DEPTH) ? c_DEPTH : op_count;
    assign w_idx_next  = r_idx + 1'b1;
    assign w_mismatch  = (r_last_result != r_op[31:16]);

    // Program store is intentionally outside the reset domain so a reset keeps it.
    always_ff @(posedge clk) begin
        if (prog_we && (r_state == c_IDLE)) begin
            r_prog[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_IDLE;
            r_count         <= '0;
            r_idx           <= '0;
            r_op            <= '0;
            r_last_result   <= '0;
            r_last_zr       <= 1'b0;
            r_last_ng       <= 1'b0;
            r_err_count     <= '0;
            r_first_err_idx <= c_NONE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_count         <= w_sat_count;
                        r_idx           <= '0;
                        r_err_count     <= '0;
                        r_first_err_idx <= c_NONE;
                        r_state         <= (w_sat_count == '0) ? c_DONE : c_INIT;
                    end
                end
                c_INIT: begin
                    r_state <= c_FETCH;
                end
                c_FETCH: begin
                    r_op    <= r_prog[r_idx[PW-1:0]];
                    r_state <= c_EXEC;
                end
                c_EXEC: begin
                    r_last_result <= alu_result;
                    r_last_zr     <= alu_zr;
                    r_last_ng     <= alu_ng;
                    r_state       <= c_CHECK;
                end
                c_CHECK: begin
                    if (w_mismatch) begin
                        r_err_count <= r_err_count + 1'b1;
                        if (r_first_err_idx == c_NONE) begin
                            r_first_err_idx <= r_idx;
                        end
                    end
                    r_idx   <= w_idx_next;
                    r_state <= (w_idx_next == r_count) ? c_DONE : c_FETCH;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // The op register holds the last issued op, so the ALU inputs stay stable between ops.
    assign address_a     = r_op[15:11];
    assign address_b     = r_op[10:6];
    assign zx            = r_op[5];
    assign nx            = r_op[4];
    assign zy            = r_op[3];
    assign ny            = r_op[2];
    assign f             = r_op[1];
    assign no            = r_op[0];

    assign initialise    = (r_state == c_INIT);
    assign busy          = (r_state != c_IDLE);
    assign done          = (r_state == c_DONE);
    assign last_result   = r_last_result;
    assign last_zr       = r_last_zr;
    assign last_ng       = r_last_ng;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Scoreboard bench for alu_op_sequencer with a Hack ALU and
//             operand memory model (mem[i]=i, mem[12]=-1 after preload).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        start = 1'b0;
    logic [4:0]  op_count = '0;
    logic        initialise;
    logic [4:0]  address_a, address_b;
    logic        zx, nx, zy, ny, f, no;
    logic [15:0] alu_result;
    logic        alu_zr, alu_ng;
    logic        busy, done;
    logic [15:0] last_result;
    logic        last_zr, last_ng;
    logic [4:0]  err_count, first_err_idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          done_cyc;
        int          busy_cycles;
        int          inits;
        logic [15:0] res;
        logic        zr;
        logic        ng;
        logic [4:0]  err;
        logic [4:0]  first;
        bit          chk_res;
    } exp_t;

    exp_t sb[$];

    alu_op_sequencer #(.PROG_DEPTH(16), .DATA_W(16), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .op_count(op_count),
        .initialise(initialise), .address_a(address_a), .address_b(address_b),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .alu_result(alu_result), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .busy(busy), .done(done), .last_result(last_result),
        .last_zr(last_zr), .last_ng(last_ng), .err_count(err_count),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand memories and Hack ALU
    logic [15:0] mem_a [32];
    logic [15:0] mem_b [32];
    logic [15:0] ax, ay, ao;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (initialise) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i] <= (i == 12) ? 16'hFFFF : 16'(i);
                mem_b[i] <= (i == 12) ? 16'hFFFF : 16'(i);
            end
        end
    end

    always_comb begin
        ax = mem_a[address_a];
        ay = mem_b[address_b];
        if (zx) ax = '0;
        if (nx) ax = ~ax;
        if (zy) ay = '0;
        if (ny) ay = ~ay;
        ao = f ? (ax + ay) : (ax & ay);
        if (no) ao = ~ao;
    end
    assign alu_result = ao;
    assign alu_zr     = (ao == 16'h0000);
    assign alu_ng     = ao[15];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Monitor: pops one expectation per done pulse
    int inits_seen = 0;
    int busy_seen  = 0;
    always @(negedge clk) begin
        if (rst) begin
            inits_seen = 0;
            busy_seen  = 0;
        end else begin
            if (initialise) inits_seen++;
            if (busy) busy_seen++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("busy_cycles", 32'(busy_seen), 32'(e.busy_cycles));
                    check("init_pulses", 32'(inits_seen), 32'(e.inits));
                    check("err_count", 32'(err_count), 32'(e.err));
                    check("first_err_idx", 32'(first_err_idx), 32'(e.first));
                    if (e.chk_res) begin
                        check("last_result", 32'(last_result), 32'(e.res));
                        check("last_zr", 32'(last_zr), 32'(e.zr));
                        check("last_ng", 32'(last_ng), 32'(e.ng));
                    end
                end
                inits_seen = 0;
                busy_seen  = 0;
            end
        end
    end

    function automatic logic [31:0] entry(logic [15:0] expv, logic [4:0] a,
                                          logic [4:0] b, logic [5:0] ctrl);
        return {expv, a, b, ctrl};
    endfunction

    task automatic prog_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic push_exp(input int s, input int n_eff, input logic [15:0] res,
                            input logic zr, input logic ng, input logic [4:0] err,
                            input logic [4:0] first, input bit chk_res);
        exp_t e;
        int d;
        d = (n_eff == 0) ? 1 : 3 * n_eff + 2;
        e.done_cyc    = s + d;
        e.busy_cycles = d;
        e.inits       = (n_eff == 0) ? 0 : 1;
        e.res         = res;
        e.zr          = zr;
        e.ng          = ng;
        e.err         = err;
        e.first       = first;
        e.chk_res     = chk_res;
        sb.push_back(e);
    endtask

    // Issue a run, then wait past its done cycle and confirm it was consumed.
    task automatic run(input int n_req, input int n_eff, input logic [15:0] res,
                       input logic zr, input logic ng, input logic [4:0] err,
                       input logic [4:0] first, input bit chk_res);
        int d;
        @(negedge clk);
        start    = 1'b1;
        op_count = 5'(n_req);
        push_exp(cyc, n_eff, res, zr, ng, err, first, chk_res);
        @(negedge clk);
        start = 1'b0;
        d = (n_eff == 0) ? 1 : 3 * n_eff + 2;
        repeat (d + 2) @(negedge clk);
        check("done_seen", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_init", 32'(initialise), 32'd0);
        check("rst_first_err", 32'(first_err_idx), 32'h1F);
        check("rst_addr_a", 32'(address_a), 32'd0);

        // 1: 1 + 2 = 3
        prog_write(4'd0, entry(16'd3, 5'd1, 5'd2, 6'b000010));
        run(1, 1, 16'd3, 1'b0, 1'b0, 5'd0, 5'h1F, 1'b1);

        // 2: -1 + 1 = 0 -> zr
        prog_write(4'd0, entry(16'd0, 5'd12, 5'd1, 6'b000010));
        run(1, 1, 16'd0, 1'b1, 1'b0, 5'd0, 5'h1F, 1'b1);

        // 3: four ops, entry 2 expects 9 but computes 3; entry 3 is 2-9 = -7
        prog_write(4'd0, entry(16'd7, 5'd3, 5'd4, 6'b000010));
        prog_write(4'd1, entry(16'd4, 5'd5, 5'd6, 6'b000000));
        prog_write(4'd2, entry(16'd9, 5'd1, 5'd2, 6'b000010));
        prog_write(4'd3, entry(16'hFFF9, 5'd2, 5'd9, 6'b010011));
        run(4, 4, 16'hFFF9, 1'b0, 1'b1, 5'd1, 5'd2, 1'b1);

        // 4: zero-length run
        run(0, 0, 16'd0, 1'b0, 1'b0, 5'd0, 5'h1F, 1'b0);

        // op_count above depth saturates to 16; entries 4..15 compute i+1
        for (int i = 4; i < 16; i++) begin
            prog_write(4'(i), entry((i == 12) ? 16'd0 : 16'(i + 1), 5'(i), 5'd1, 6'b000010));
        end
        run(31, 16, 16'd16, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1);

        // 5: reset during EXEC of op 1 of 3
        @(negedge clk);
        start    = 1'b1;
        op_count = 5'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_exec_addr_a", 32'(address_a), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(last_result), 32'd0);
        check("abort_err", 32'(err_count), 32'd0);
        check("abort_first_err", 32'(first_err_idx), 32'h1F);
        check("abort_addr_a", 32'(address_a), 32'd0);
        check("abort_f", 32'(f), 32'd0);
        repeat (12) @(negedge clk);
        run(3, 3, 16'd3, 1'b0, 1'b0, 5'd1, 5'd2, 1'b1);

        // 6: start and prog_we while busy are ignored
        @(negedge clk);
        start    = 1'b1;
        op_count = 5'd2;
        s        = cyc;
        push_exp(s, 2, 16'd4, 1'b0, 1'b0, 5'd0, 5'h1F, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start     = 1'b1;
        op_count  = 5'd0;
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = entry(16'h1234, 5'd9, 5'd9, 6'b000010);
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_run_done_seen", 32'(sb.size()), 32'd0);
        check("idle_after_busy_run", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
